// File: rtl/mm_port_arbiter.sv
// Shares the main-memory port between I-side and D-side line bursts, sequencing beats and addresses.
// Latency: grant registered one cycle after request; beat strobes/done are combinational on mem_valid_mm.
// Backpressure: mem_valid_mm=0 stalls the beat counter; bursts are non-preemptible once granted.
module mm_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W         = $clog2(WORDS_PER_LINE),
    localparam int OFF           = IDX_W + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              req_d,
    input  logic              we_d,
    input  logic              lock_d,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] wdata_d,
    input  logic              mem_valid_mm,
    input  logic [DATA_W-1:0] rdata_mm,
    output logic              re_mm,
    output logic              we_mm,
    output logic [ADDR_W-1:0] addr_mm,
    output logic [DATA_W-1:0] wdata_mm,
    output logic [DATA_W-1:0] rdata_out,
    output logic              gnt_i,
    output logic              gnt_d,
    output logic              beat_valid_i,
    output logic              beat_valid_d,
    output logic [IDX_W-1:0]  beat_idx,
    output logic              done_i,
    output logic              done_d
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] beat_idx_q;
    logic             last_win_d_q;   // 1: D won the most recent burst
    logic             granted;
    logic             last_beat;

    // Byte/beat offset bits of the request addresses are regenerated internally.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[OFF-1:0], addr_d[OFF-1:0]};

    assign granted   = (state_q != ST_IDLE);
    assign last_beat = granted && mem_valid_mm && (beat_idx_q == LAST_BEAT);

    // State register; async reset abandons any partial burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat counter and round-robin history; counter wraps to 0 on the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_idx_q   <= '0;
            last_win_d_q <= 1'b1;
        end else if (granted && mem_valid_mm) begin
            beat_idx_q <= beat_idx_q + 1'b1;
            if (last_beat) begin
                last_win_d_q <= (state_q == ST_GNT_D);
            end
        end
    end

    // Next-state: arbitrate only from IDLE; a locked D burst chains straight into another D burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i && req_d) begin
                    state_d = last_win_d_q ? ST_GNT_I : ST_GNT_D;
                end else if (req_i) begin
                    state_d = ST_GNT_I;
                end else if (req_d) begin
                    state_d = ST_GNT_D;
                end
            end
            ST_GNT_I: begin
                if (last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (last_beat && !lock_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: memory controls, address and data routing follow the owner; all zero in IDLE.
    always_comb begin
        re_mm        = 1'b0;
        we_mm        = 1'b0;
        addr_mm      = '0;
        wdata_mm     = '0;
        rdata_out    = '0;
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;
        beat_valid_i = 1'b0;
        beat_valid_d = 1'b0;
        done_i       = 1'b0;
        done_d       = 1'b0;
        beat_idx     = beat_idx_q;
        case (state_q)
            ST_GNT_I: begin
                gnt_i        = 1'b1;
                re_mm        = 1'b1;
                addr_mm      = {addr_i[ADDR_W-1:OFF], beat_idx_q, 2'b00};
                rdata_out    = rdata_mm;
                beat_valid_i = mem_valid_mm;
                done_i       = last_beat;
            end
            ST_GNT_D: begin
                gnt_d        = 1'b1;
                re_mm        = ~we_d;
                we_mm        = we_d;
                addr_mm      = {addr_d[ADDR_W-1:OFF], beat_idx_q, 2'b00};
                wdata_mm     = wdata_d;
                rdata_out    = rdata_mm;
                beat_valid_d = mem_valid_mm;
                done_d       = last_beat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mm_port_arbiter.sv
module tb_mm_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WPL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_i, req_d, we_d, lock_d, mem_valid_mm;
    logic [AW-1:0] addr_i, addr_d;
    logic [DW-1:0] wdata_d, rdata_mm;
    logic          re_mm, we_mm, gnt_i, gnt_d, beat_valid_i, beat_valid_d, done_i, done_d;
    logic [AW-1:0] addr_mm;
    logic [DW-1:0] wdata_mm, rdata_out;
    logic [1:0]    beat_idx;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .addr_i(addr_i),
        .req_d(req_d), .we_d(we_d), .lock_d(lock_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .mem_valid_mm(mem_valid_mm), .rdata_mm(rdata_mm),
        .re_mm(re_mm), .we_mm(we_mm), .addr_mm(addr_mm), .wdata_mm(wdata_mm),
        .rdata_out(rdata_out), .gnt_i(gnt_i), .gnt_d(gnt_d),
        .beat_valid_i(beat_valid_i), .beat_valid_d(beat_valid_d),
        .beat_idx(beat_idx), .done_i(done_i), .done_d(done_d)
    );

    // ---------------- reference model: owner + number of beats transferred ----------------
    int m_owner;      // 0 none, 1 I-side, 2 D-side
    int m_beats;      // beats already completed in the current burst
    bit m_last_d;     // most recent burst winner was D

    logic          e_re, e_we, e_gi, e_gd, e_bvi, e_bvd, e_di, e_dd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [1:0]    e_bidx;

    function automatic void model_reset();
        m_owner  = 0;
        m_beats  = 0;
        m_last_d = 1'b1;
    endfunction

    function automatic void model_eval();
        logic [AW-1:0] base;
        e_gi    = reset && (m_owner == 1);
        e_gd    = reset && (m_owner == 2);
        e_re    = e_gi || (e_gd && !we_d);
        e_we    = e_gd && we_d;
        base    = e_gi ? addr_i : addr_d;
        e_addr  = (e_gi || e_gd) ? AW'((base - (base % 16)) + m_beats * 4) : '0;
        e_wdata = e_gd ? wdata_d : '0;
        e_rdata = (e_gi || e_gd) ? rdata_mm : '0;
        e_bvi   = e_gi && mem_valid_mm;
        e_bvd   = e_gd && mem_valid_mm;
        e_bidx  = reset ? 2'(m_beats) : 2'd0;
        e_di    = e_bvi && (m_beats == WPL - 1);
        e_dd    = e_bvd && (m_beats == WPL - 1);
    endfunction

    function automatic void model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_owner == 0) begin
            if (req_i && req_d) m_owner = m_last_d ? 1 : 2;
            else if (req_i)     m_owner = 1;
            else if (req_d)     m_owner = 2;
        end else if (mem_valid_mm) begin
            m_beats++;
            if (m_beats == WPL) begin
                m_beats  = 0;
                m_last_d = (m_owner == 2);
                if (!(m_owner == 2 && lock_d)) m_owner = 0;
            end
        end
    endfunction

    function automatic logic [105:0] obs_vec();
        return {re_mm, we_mm, addr_mm, wdata_mm, rdata_out, gnt_i, gnt_d,
                beat_valid_i, beat_valid_d, beat_idx, done_i, done_d};
    endfunction

    function automatic logic [105:0] exp_vec();
        return {e_re, e_we, e_addr, e_wdata, e_rdata, e_gi, e_gd,
                e_bvi, e_bvd, e_bidx, e_di, e_dd};
    endfunction

    // One clock: model and DUT both consume the inputs present at the rising edge.
    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 0; req_d = 0; we_d = 0; lock_d = 0; mem_valid_mm = 0;
        addr_i = '0; addr_d = '0; wdata_d = '0; rdata_mm = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        advance();
        advance();
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        req_i = 1; req_d = 1; mem_valid_mm = 1; rdata_mm = $urandom; wdata_d = $urandom;
        addr_i = $urandom; addr_d = $urandom;
        for (int c = 0; c < 3; c++) begin
            #3;
            n_checks++;
            if (obs_vec() !== '0) $display("FAIL reset_low cyc%0d: got %h want 0", c, obs_vec());
            else n_pass++;
            advance();
        end
        idle_inputs();
        mem_valid_mm = 1; rdata_mm = 32'hDEAD_BEEF; wdata_d = 32'h1111_2222;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_checks++;
            if (obs_vec() !== '0) $display("FAIL idle_ignores_valid cyc%0d: got %h want 0", c, obs_vec());
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_single_i();
        bit drop;
        do_reset();
        req_i = 1; addr_i = 32'h1234; mem_valid_mm = 1; rdata_mm = 32'hA5A5_0001;
        for (int c = 0; c < 6; c++) begin
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL single_i_model cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            n_checks++;
            if (c >= 1 && c <= 4) begin
                if ({gnt_i, gnt_d, addr_mm, done_i} !== {1'b1, 1'b0, 32'h1230 + 32'(4 * (c - 1)), c == 4})
                    $display("FAIL single_i_beat cyc%0d: got gnt_i=%b addr=%h done=%b want gnt_i=1 addr=%h done=%b",
                             c, gnt_i, addr_mm, done_i, 32'h1230 + 32'(4 * (c - 1)), c == 4);
                else n_pass++;
            end else begin
                if ({gnt_i, gnt_d} !== 2'b00) $display("FAIL single_i_idle cyc%0d: got gnt=%b%b want 00", c, gnt_i, gnt_d);
                else n_pass++;
            end
            drop = e_di;
            advance();
            if (drop) req_i = 0;
        end
    endtask

    task automatic test_round_robin();
        bit di, dd;
        int gi_first = -1, gd_first = -1, di_cyc = -1;
        do_reset();
        req_i = 1; req_d = 1; addr_i = 32'h40; addr_d = 32'h8000; mem_valid_mm = 1;
        for (int c = 0; c < 12; c++) begin
            rdata_mm = $urandom; wdata_d = $urandom;
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rr_model cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (gnt_i && gi_first < 0) gi_first = c;
            if (gnt_d && gd_first < 0) gd_first = c;
            if (done_i && di_cyc < 0)  di_cyc = c;
            di = e_di; dd = e_dd;
            advance();
            if (di) req_i = 0;
            if (dd) req_d = 0;
        end
        n_checks++;
        if ({gi_first, di_cyc, gd_first} !== {32'sd1, 32'sd4, 32'sd6})
            $display("FAIL rr_order: got gnt_i@%0d done_i@%0d gnt_d@%0d want 1 4 6", gi_first, di_cyc, gd_first);
        else n_pass++;
    endtask

    task automatic test_lock();
        bit di, dd;
        int n_dd = 0, wb = 0, rd = 0, d_cycles = 0, gi_first = -1;
        do_reset();
        req_d = 1; we_d = 1; lock_d = 1; addr_d = 32'h2000; mem_valid_mm = 1; addr_i = 32'h3000;
        for (int c = 0; c < 14; c++) begin
            rdata_mm = $urandom; wdata_d = $urandom;
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL lock_model cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (beat_valid_d && we_mm) wb++;
            if (beat_valid_d && re_mm) rd++;
            if (c >= 1 && c <= 8 && gnt_d) d_cycles++;
            if (gnt_i && gi_first < 0) gi_first = c;
            di = e_di; dd = e_dd;
            advance();
            if (c == 0) req_i = 1;
            if (di) req_i = 0;
            if (dd) begin
                n_dd++;
                if (n_dd == 1) begin we_d = 0; lock_d = 0; end
                else req_d = 0;
            end
        end
        n_checks++;
        if ({wb, rd, d_cycles, gi_first} !== {32'sd4, 32'sd4, 32'sd8, 32'sd10})
            $display("FAIL lock_chain: got wb=%0d rd=%0d gnt_d_cycles=%0d gnt_i@%0d want 4 4 8 10",
                     wb, rd, d_cycles, gi_first);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit pat[7]      = '{1, 0, 0, 1, 0, 1, 1};
        int bidx_exp[7] = '{0, 1, 1, 1, 2, 2, 3};
        bit di;
        do_reset();
        req_i = 1; addr_i = 32'h100; mem_valid_mm = 1;   // valid while IDLE must be ignored
        for (int c = 0; c < 9; c++) begin
            if (c >= 1 && c <= 7) mem_valid_mm = pat[c-1];
            else if (c == 8)      mem_valid_mm = 1;
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL stall_model cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (c >= 1 && c <= 7) begin
                n_checks++;
                if ({beat_idx, done_i} !== {2'(bidx_exp[c-1]), c == 7})
                    $display("FAIL stall_idx cyc%0d: got idx=%0d done=%b want idx=%0d done=%b",
                             c, beat_idx, done_i, bidx_exp[c-1], c == 7);
                else n_pass++;
            end
            di = e_di;
            advance();
            if (di) req_i = 0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_i = 1; addr_i = 32'h500; mem_valid_mm = 1; rdata_mm = 32'h0BAD_CAFE;
        for (int c = 0; c < 3; c++) begin
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rstmid_pre cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            advance();
        end
        #3;
        n_checks++;
        if ({gnt_i, beat_idx} !== 3'b110) $display("FAIL rstmid_beat2: got gnt_i=%b idx=%0d want 1 2", gnt_i, beat_idx);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== '0) $display("FAIL rstmid_zero: got %h want 0", obs_vec());
        else n_pass++;
        advance();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rstmid_post cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if ({gnt_i, beat_idx, addr_mm} !== {1'b1, 2'd0, 32'h500})
                    $display("FAIL rstmid_restart: got gnt_i=%b idx=%0d addr=%h want 1 0 00000500", gnt_i, beat_idx, addr_mm);
                else n_pass++;
            end
            advance();
        end
        req_i = 0;
        advance();
        advance();
    endtask

    task automatic test_drop_req();
        int beats = 0, dd_cyc = -1;
        do_reset();
        req_d = 1; we_d = 0; lock_d = 0; addr_d = 32'h7770; mem_valid_mm = 1;
        for (int c = 0; c < 7; c++) begin
            rdata_mm = $urandom;
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL drop_model cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (beat_valid_d) beats++;
            if (done_d) dd_cyc = c;
            advance();
            if (c == 1) req_d = 0;
        end
        n_checks++;
        if ({beats, dd_cyc} !== {32'sd4, 32'sd4})
            $display("FAIL drop_complete: got beats=%0d done_d@%0d want 4 4", beats, dd_cyc);
        else n_pass++;
    endtask

    task automatic test_random();
        bit di, dd, lk;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            mem_valid_mm = ($urandom_range(3) != 0);
            rdata_mm     = $urandom;
            wdata_d      = $urandom;
            #3; model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
            di = e_di; dd = e_dd; lk = lock_d;
            advance();
            if (di) req_i = 0;
            else if (!req_i && $urandom_range(2) == 0) begin
                req_i = 1; addr_i = $urandom;
            end
            if (dd) begin
                if (lk) begin
                    we_d = $urandom; lock_d = $urandom; addr_d = $urandom;
                end else begin
                    req_d = 0;
                end
            end else if (!req_d && $urandom_range(2) == 0) begin
                req_d = 1; we_d = $urandom; lock_d = $urandom; addr_d = $urandom;
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_single_i();
        test_round_robin();
        test_lock();
        test_stall();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
